// File: rtl/inner_product_pkg.sv
// Shared widths and constant helpers for the inner-product accumulator.
// Everything here is elaboration-time only.
package inner_product_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_LANES  = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_OUT_W  = 8;
  localparam int DEF_SHIFT  = 7;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Half-LSB bias so the arithmetic shift rounds half up; zero when no shift.
  function automatic longint round_bias(input int shift);
    return (shift > 0) ? (longint'(1) <<< (shift - 1)) : longint'(0);
  endfunction

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/ip_adder_tree.sv
// Balanced signed adder tree over LANES packed operands, result registered.
// Each level halves the operand count; the enable freezes the output register.
module ip_adder_tree #(
  parameter int LANES = 16,
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic [LANES*IN_W-1:0]   din,
  output logic signed [OUT_W-1:0] sum
);

  localparam int LOG = $clog2(LANES);

  for (genvar l = 0; l <= LOG; l++) begin : g_lvl
    logic signed [OUT_W-1:0] v [LANES >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < LANES; i++) begin : g_in
        assign v[i] = OUT_W'($signed(din[i*IN_W +: IN_W]));
      end
    end else begin : g_add
      for (genvar i = 0; i < (LANES >> l); i++) begin : g_node
        assign v[i] = g_lvl[l-1].v[2*i] + g_lvl[l-1].v[2*i+1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en) sum <= g_lvl[LOG].v[0];
  end

endmodule

// File: rtl/inner_product_acc.sv
// Pipelined multi-beat inner product: multiply, tree-sum, accumulate, then
// round/shift/saturate one result per vector with a clip flag.
module inner_product_acc
  import inner_product_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LANES  = DEF_LANES,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [LANES*DATA_W-1:0]  iW,
  input  logic [LANES*DATA_W-1:0]  iX,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  oInnerout,
  output logic                     oSat
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [ACC_W:0] ACC_MAX  = (ACC_W+1)'(sat_max(ACC_W));
  localparam logic signed [ACC_W:0] ACC_MIN  = (ACC_W+1)'(sat_min(ACC_W));
  localparam logic signed [ACC_W:0] OUT_MAX  = (ACC_W+1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] OUT_MIN  = (ACC_W+1)'(sat_min(OUT_W));
  localparam logic signed [ACC_W:0] RND_BIAS = (ACC_W+1)'(round_bias(SHIFT));

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] v,
                                                      output logic clip);
    clip = (v > ACC_MAX) || (v < ACC_MIN);
    if (v > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    else                  return v[ACC_W-1:0];
  endfunction

  function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] s);
    logic signed [ACC_W:0] t;
    t = (ACC_W+1)'(s) + RND_BIAS;
    return t >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W:0] v,
                                                      output logic clip);
    clip = (v > OUT_MAX) || (v < OUT_MIN);
    if (v > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return v[OUT_W-1:0];
  endfunction

  logic                    stall;
  logic signed [DATA_W-1:0] w_l [LANES];
  logic signed [DATA_W-1:0] x_l [LANES];
  logic [LANES*PW-1:0]     prod_p0;
  logic                    vld_p0, last_p0;
  logic signed [ACC_W-1:0] sum_p1;
  logic                    vld_p1, last_p1;
  logic signed [ACC_W-1:0] acc_p2;
  logic                    sticky_p2;
  logic signed [ACC_W:0]   sum_wide;
  logic signed [ACC_W-1:0] sum_sat;
  logic signed [ACC_W:0]   rnd;
  logic signed [OUT_W-1:0] out_q;
  logic                    acc_clip, out_clip;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_l[i] = $signed(iW[lane_lsb(i, DATA_W) +: DATA_W]);
    assign x_l[i] = $signed(iX[lane_lsb(i, DATA_W) +: DATA_W]);
  end

  // ---- S1: lane products, captured on the acceptance edge
  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int i = 0; i < LANES; i++) begin
        prod_p0[lane_lsb(i, PW) +: PW] <= PW'(w_l[i]) * PW'(x_l[i]);
      end
    end
  end

  // ---- S2: balanced sum of the products
  ip_adder_tree #(
    .LANES (LANES),
    .IN_W  (PW),
    .OUT_W (ACC_W)
  ) u_tree (
    .clk (clk),
    .en  (!stall),
    .din (prod_p0),
    .sum (sum_p1)
  );

  // ---- S3: accumulate, then round/shift/clip on the last beat
  always_comb begin
    acc_clip = 1'b0;
    out_clip = 1'b0;
    sum_wide = (ACC_W+1)'(acc_p2) + (ACC_W+1)'(sum_p1);
    sum_sat  = sat_acc(sum_wide, acc_clip);
    rnd      = round_shift(sum_sat);
    out_q    = sat_out(rnd, out_clip);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      acc_p2    <= '0;
      sticky_p2 <= 1'b0;
      out_valid <= 1'b0;
      oInnerout <= '0;
      oSat      <= 1'b0;
    end else if (!stall) begin
      vld_p0    <= in_valid;
      last_p0   <= in_last;
      vld_p1    <= vld_p0;
      last_p1   <= last_p0;
      out_valid <= vld_p1 && last_p1;
      if (vld_p1) begin
        if (last_p1) begin
          acc_p2    <= '0;
          sticky_p2 <= 1'b0;
          oInnerout <= out_q;
          oSat      <= sticky_p2 || acc_clip || out_clip;
        end else begin
          acc_p2    <= sum_sat;
          sticky_p2 <= sticky_p2 || acc_clip;
        end
      end
    end
  end

endmodule

// File: tb/tb_inner_product_acc.sv
// Directed-vector bench for inner_product_acc (16 lanes, 8-bit, SHIFT=7):
// table of vectors with hand-computed results plus latency/stall/reset sequences.
module tb_inner_product_acc;

  localparam int DATA_W = 8;
  localparam int LANES  = 16;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 8;
  localparam int SHIFT  = 7;
  localparam int VW     = LANES * DATA_W;

  logic clk = 1'b0;
  logic resetn, in_valid, in_ready, in_last, out_valid, out_ready, oSat;
  logic [VW-1:0] iW, iX;
  logic signed [OUT_W-1:0] oInnerout;

  inner_product_acc #(
    .DATA_W (DATA_W), .LANES (LANES), .ACC_W (ACC_W), .OUT_W (OUT_W), .SHIFT (SHIFT)
  ) dut (
    .clk (clk), .resetn (resetn), .in_valid (in_valid), .in_ready (in_ready),
    .in_last (in_last), .iW (iW), .iX (iX), .out_valid (out_valid),
    .out_ready (out_ready), .oInnerout (oInnerout), .oSat (oSat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VW-1:0] w;
    logic [VW-1:0] x;
    int            nb;
    int            gap;
    int            ev;
    logic          es;
    string         nm;
  } vec_t;

  vec_t tbl[$];
  int   got_v[$];
  logic got_s[$];
  int   got_c[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (resetn && out_valid && out_ready) begin
      got_v.push_back(int'(oInnerout));
      got_s.push_back(oSat);
      got_c.push_back(cyc);
    end
  end

  function automatic logic [VW-1:0] pk(input int v[LANES]);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DATA_W +: DATA_W] = DATA_W'(v[i]);
    return r;
  endfunction

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  task automatic add(input int w[LANES], input int x[LANES], input int nb, input int gap,
                     input int ev, input logic es, input string nm);
    vec_t t;
    t.w = pk(w); t.x = pk(x); t.nb = nb; t.gap = gap; t.ev = ev; t.es = es; t.nm = nm;
    tbl.push_back(t);
  endtask

  task automatic send(input logic [VW-1:0] w, input logic [VW-1:0] x, input logic last);
    int t;
    @(negedge clk);
    iW = w; iX = x; in_last = last; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic get(input string n, output int v, output logic s, output int c);
    int t;
    t = 0;
    while (got_v.size() == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({n, "_arrived"}, got_v.size() > 0, 1);
    if (got_v.size() > 0) begin
      v = got_v.pop_front(); s = got_s.pop_front(); c = got_c.pop_front();
    end else begin
      v = 9999; s = 1'bx; c = -1;
    end
  endtask

  task automatic flush_q();
    got_v.delete(); got_s.delete(); got_c.delete();
  endtask

  int wv[LANES], xv[LANES];
  logic [VW-1:0] v64x2, v_p1, v_m1, v_z, v_one64, v_m1_65, v_m1_64, v_base_w, v_base_x;
  int rv, rc, c0;
  logic rs;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; iW = '0; iX = '0;

    wv = '{127, 30, 0, 17, -120, -30, -12, 87, 65, 13, 127, 127, -127, -127, -1, -1};
    xv = '{127, 127, 127, 127, 120, 1, 14, -56, -43, 87, 127, 127, -127, -127, -1, -1};
    add(wv, xv, 1, 0, 127, 1'b1, "baseline");
    v_base_w = pk(wv); v_base_x = pk(xv);
    wv = '{default: 64}; xv = '{default: 2};
    add(wv, xv, 2, 0, 32, 1'b0, "two_beat");
    add(wv, xv, 1, 0, 16, 1'b0, "one_beat");
    v64x2 = pk(wv); v_z = pk(xv);
    wv = '{default: 0}; xv = '{default: 0};
    wv[0] = -1; xv[0] = 64; add(wv, xv, 1, 0, 0, 1'b0, "rnd_m64");   v_m1_64 = pk(wv); v_z = pk(xv);
    xv[0] = 65;             add(wv, xv, 1, 0, -1, 1'b0, "rnd_m65");
    wv[0] = 1;  xv[0] = 63; add(wv, xv, 1, 0, 0, 1'b0, "rnd_p63");
    xv[0] = 64;             add(wv, xv, 1, 0, 1, 1'b0, "rnd_p64");
    wv = '{default: 127}; xv = '{default: -128};
    add(wv, xv, 1, 0, -128, 1'b1, "neg_sat");
    wv = '{default: 0}; xv = '{default: 0};
    wv[0] = 127; xv[0] = 127; wv[1] = 1; xv[1] = 63;
    add(wv, xv, 1, 0, 127, 1'b0, "max_exact");
    xv[1] = 127; wv[2] = 1; xv[2] = 64;
    add(wv, xv, 1, 0, 127, 1'b1, "max_over");
    wv = '{default: 0}; xv = '{default: 0};
    wv[0] = -128; xv[0] = 127; wv[1] = -1; xv[1] = 65;
    add(wv, xv, 1, 0, -128, 1'b0, "min_exact");
    xv[1] = 127; wv[2] = -1; xv[2] = 66;
    add(wv, xv, 1, 0, -128, 1'b1, "min_under");
    wv = '{default: 64}; xv = '{default: 2};
    add(wv, xv, 2, 3, 32, 1'b0, "bubbles");

    wv = '{default: 0}; xv = '{default: 0};
    wv[0] = 1;  xv[0] = 64; v_one64 = pk(wv); v_z = pk(xv); v_p1 = v_one64;
    wv[0] = -1; xv[0] = 65; v_m1 = pk(wv); v_m1_65 = pk(xv);
    xv[0] = 64; v_one64 = pk(xv);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", oInnerout, 0);
    chk("rst_sat", oSat, 0);
    chk("rst_in_ready", in_ready, 1);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Latency: accepted at edge N, seen by the consumer at edge N+3
    send(v_base_w, v_base_x, 1'b1);
    @(negedge clk); chk("lat_edge1_valid", out_valid, 0);
    @(negedge clk); chk("lat_edge2_valid", out_valid, 0);
    @(negedge clk); chk("lat_edge3_valid", out_valid, 1);
    chk("lat_value", oInnerout, 127);
    get("lat", rv, rs, rc);
    flush_q();

    // Table-driven vectors
    for (int i = 0; i < tbl.size(); i++) begin
      for (int b = 0; b < tbl[i].nb; b++) begin
        send(tbl[i].w, tbl[i].x, b == tbl[i].nb - 1);
        repeat (tbl[i].gap) @(negedge clk);
      end
      get(tbl[i].nm, rv, rs, rc);
      chk({tbl[i].nm, "_val"}, rv, tbl[i].ev);
      chk({tbl[i].nm, "_sat"}, rs, tbl[i].es);
    end

    // Back-to-back single-beat vectors
    repeat (5) @(negedge clk);
    flush_q();
    send(v64x2, pk('{default: 2}), 1'b1);
    send(v_p1, v_one64, 1'b1);
    send(v_base_w, v_base_x, 1'b1);
    send(v_m1, v_m1_65, 1'b1);
    get("b2b0", rv, rs, c0); chk("b2b0_val", rv, 16);
    get("b2b1", rv, rs, rc); chk("b2b1_val", rv, 1);   chk("b2b1_cyc", rc - c0, 1);
    get("b2b2", rv, rs, rc); chk("b2b2_val", rv, 127); chk("b2b2_cyc", rc - c0, 2);
    get("b2b3", rv, rs, rc); chk("b2b3_val", rv, -1);  chk("b2b3_cyc", rc - c0, 3);

    // Backpressure: hold the consumer off with three more vectors behind
    repeat (5) @(negedge clk);
    flush_q();
    out_ready = 1'b0;
    send(v64x2, pk('{default: 2}), 1'b1);
    send(v_p1, v_one64, 1'b1);
    send(v_m1, v_m1_65, 1'b1);
    @(negedge clk);
    iW = v_m1_64; iX = v_one64; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_hold_val", oInnerout, 16);
      @(negedge clk);
    end
    chk("bp_no_early", got_v.size(), 0);
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0;
    get("bp0", rv, rs, rc); chk("bp0_val", rv, 16);
    get("bp1", rv, rs, rc); chk("bp1_val", rv, 1);
    get("bp2", rv, rs, rc); chk("bp2_val", rv, -1);
    get("bp3", rv, rs, rc); chk("bp3_val", rv, 0);
    repeat (10) @(negedge clk);
    chk("bp_no_extra", got_v.size(), 0);

    // Reset mid-vector with a result pending
    out_ready = 1'b0;
    send(v_p1, v_one64, 1'b1);
    send(v64x2, pk('{default: 2}), 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_pending_valid", out_valid, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_out", oInnerout, 0);
    chk("mid_rst_sat", oSat, 0);
    @(negedge clk);
    resetn = 1'b1; out_ready = 1'b1;
    flush_q();
    send(v64x2, pk('{default: 2}), 1'b1);
    get("fresh", rv, rs, rc);
    chk("fresh_val", rv, 16);
    chk("fresh_sat", rs, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
